vga_pattern_gen: RTL and testbench

Parametrised VGA pixel-stage test-pattern generator. It sits between the `vga` timing block (x, y, active, vSync) and the colour pins. It generalises the fixed-bars top level to:
- configurable colour depth, coordinate width and marker column;
- four selectable patterns, one of them animated;
- mode changes latched only at frame boundaries, plus a free-running frame counter;
- registered, blanked RGB outputs with one-cycle latency.

---
 rtl/vga_pattern_gen.sv | 181 ++++++++++++++++++
 tb/tb_vga_pattern_gen.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/vga_pattern_gen.sv
// Pixel-stage test-pattern generator for the vga timing block.
// Mode switches happen only on a vsync leading edge; RGB is registered and blanked outside the active area.

module vga_pattern_gen #(
    parameter int                 COLOR_W     = 4,
    parameter int                 X_W         = 10,
    parameter int                 Y_W         = 10,
    parameter int                 FRAME_W     = 8,
    parameter int                 CHECK_LOG2  = 4,
    parameter int                 MARKER_X    = 256,
    parameter int                 SCROLL_STEP = 1,
    parameter logic               VSYNC_POL   = 1'b0,
    parameter logic [COLOR_W-1:0] SOLID_R     = {COLOR_W{1'b1}},
    parameter logic [COLOR_W-1:0] SOLID_G     = {COLOR_W{1'b0}},
    parameter logic [COLOR_W-1:0] SOLID_B     = {COLOR_W{1'b0}},
    parameter logic [1:0]         INIT_MODE   = 2'd0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               active,
    input  logic [X_W-1:0]     x,
    input  logic [Y_W-1:0]     y,
    input  logic               vsync,
    input  logic [1:0]         mode_req,
    output logic [COLOR_W-1:0] R,
    output logic [COLOR_W-1:0] G,
    output logic [COLOR_W-1:0] B,
    output logic [1:0]         cur_mode,
    output logic [FRAME_W-1:0] frame_cnt
);

    typedef enum logic [1:0] {
        MODE_BARS     = 2'd0,
        MODE_CHECKER  = 2'd1,
        MODE_GRADIENT = 2'd2,
        MODE_SOLID    = 2'd3
    } mode_t;

    localparam logic [COLOR_W-1:0] C_MAX    = {COLOR_W{1'b1}};
    localparam logic [COLOR_W-1:0] C_ZERO   = {COLOR_W{1'b0}};
    localparam logic [X_W-1:0]     MARKER_C = X_W'(MARKER_X);
    localparam logic [X_W-1:0]     STEP_C   = X_W'(SCROLL_STEP);

    mode_t              cur_mode_r;
    logic [FRAME_W-1:0] frame_cnt_r;
    logic               vsync_d_r;
    logic [COLOR_W-1:0] r_r;
    logic [COLOR_W-1:0] g_r;
    logic [COLOR_W-1:0] b_r;

    logic               boundary_s;
    logic [X_W-1:0]     scroll_s;
    logic [X_W-1:0]     sx_s;
    logic [COLOR_W-1:0] r_s;
    logic [COLOR_W-1:0] g_s;
    logic [COLOR_W-1:0] b_s;
    logic               unused_s;

    assign boundary_s = (vsync == VSYNC_POL) && (vsync_d_r != VSYNC_POL);
    // Truncating both operands to X_W keeps the product correct modulo 2^X_W.
    assign scroll_s   = X_W'(frame_cnt_r) * STEP_C;
    assign sx_s       = x + scroll_s;
    assign unused_s   = ^{y, sx_s};

    // Frame boundary tracking: vsync delay, mode latch and frame counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d_r   <= ~VSYNC_POL;
            cur_mode_r  <= mode_t'(INIT_MODE);
            frame_cnt_r <= {FRAME_W{1'b0}};
        end else begin
            vsync_d_r <= vsync;
            if (boundary_s) begin
                cur_mode_r  <= mode_t'(mode_req);
                frame_cnt_r <= frame_cnt_r + FRAME_W'(1);
            end else begin
                cur_mode_r  <= cur_mode_r;
                frame_cnt_r <= frame_cnt_r;
            end
        end
    end

    // Unregistered pattern colour for the current pixel in the current mode.
    always_comb begin
        r_s = C_ZERO;
        g_s = C_ZERO;
        b_s = C_ZERO;
        case (cur_mode_r)
            MODE_BARS: begin
                if (x == MARKER_C) begin
                    r_s = C_MAX;
                    g_s = C_MAX;
                    b_s = C_MAX;
                end else begin
                    r_s = y[3] ? C_MAX : C_ZERO;
                    g_s = (x[5] ^ x[6]) ? C_MAX : C_ZERO;
                    b_s = x[4] ? C_MAX : C_ZERO;
                end
            end
            MODE_CHECKER: begin
                if (x[CHECK_LOG2] ^ y[CHECK_LOG2]) begin
                    r_s = C_MAX;
                    g_s = C_MAX;
                    b_s = C_MAX;
                end else begin
                    r_s = C_ZERO;
                    g_s = C_ZERO;
                    b_s = C_ZERO;
                end
            end
            MODE_GRADIENT: begin
                r_s = sx_s[COLOR_W+3:4];
                g_s = y[COLOR_W+3:4];
                b_s = ~sx_s[COLOR_W+3:4];
            end
            MODE_SOLID: begin
                r_s = SOLID_R;
                g_s = SOLID_G;
                b_s = SOLID_B;
            end
            default: begin
                r_s = C_ZERO;
                g_s = C_ZERO;
                b_s = C_ZERO;
            end
        endcase
    end

    // Output register with blanking outside the visible region.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_r <= C_ZERO;
            g_r <= C_ZERO;
            b_r <= C_ZERO;
        end else if (!active) begin
            r_r <= C_ZERO;
            g_r <= C_ZERO;
            b_r <= C_ZERO;
        end else begin
            r_r <= r_s;
            g_r <= g_s;
            b_r <= b_s;
        end
    end

    assign R         = r_r;
    assign G         = g_r;
    assign B         = b_r;
    assign cur_mode  = cur_mode_r;
    assign frame_cnt = frame_cnt_r;

    vga_pattern_gen_checker #(
        .COLOR_W (COLOR_W)
    ) u_checker (
        .clk    (clk),
        .rst_n  (rst_n),
        .active (active),
        .R      (r_r),
        .G      (g_r),
        .B      (b_r)
    );

endmodule

// Property checks on the generator outputs.
module vga_pattern_gen_checker #(
    parameter int COLOR_W = 4
) (
    input logic               clk,
    input logic               rst_n,
    input logic               active,
    input logic [COLOR_W-1:0] R,
    input logic [COLOR_W-1:0] G,
    input logic [COLOR_W-1:0] B
);

    // A pixel sampled while blanked must come out black one cycle later.
    a_blank: assert property (@(posedge clk) disable iff (!rst_n)
        !$past(active) |-> ((R == {COLOR_W{1'b0}}) && (G == {COLOR_W{1'b0}}) && (B == {COLOR_W{1'b0}})));

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen: a default 4-bit build and an 8-bit build sharing the same stimulus.

module tb_vga_pattern_gen;

    logic       clk;
    logic       rst_n;
    logic       active;
    logic [9:0] x;
    logic [9:0] y;
    logic       vsync;
    logic [1:0] mode_req;

    logic [3:0] r4, g4, b4;
    logic [1:0] mode4;
    logic [7:0] fc4;
    logic [7:0] r8, g8, b8;
    logic [1:0] mode8;
    logic [7:0] fc8;

    int n_tests;
    int n_fail;

    vga_pattern_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .active    (active),
        .x         (x),
        .y         (y),
        .vsync     (vsync),
        .mode_req  (mode_req),
        .R         (r4),
        .G         (g4),
        .B         (b4),
        .cur_mode  (mode4),
        .frame_cnt (fc4)
    );

    vga_pattern_gen #(
        .COLOR_W (8),
        .X_W     (12),
        .Y_W     (12)
    ) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .active    (active),
        .x         ({2'b00, x}),
        .y         ({2'b00, y}),
        .vsync     (vsync),
        .mode_req  (mode_req),
        .R         (r8),
        .G         (g8),
        .B         (b8),
        .cur_mode  (mode8),
        .frame_cnt (fc8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle vsync pulse (active-low): boundary on the low cycle.
    task automatic frame(input logic [1:0] req);
        mode_req = req;
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        tick();
        vsync = 1'b1;
    endtask

    task automatic rgb4(input string tag, input logic [3:0] er, input logic [3:0] eg, input logic [3:0] eb);
        check({tag, ".R"}, {28'd0, r4}, {28'd0, er});
        check({tag, ".G"}, {28'd0, g4}, {28'd0, eg});
        check({tag, ".B"}, {28'd0, b4}, {28'd0, eb});
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        x        = 10'($urandom);
        y        = 10'($urandom);
        active   = 1'($urandom);
        vsync    = 1'($urandom);
        mode_req = 2'($urandom);
        #3;
        rgb4("reset", 4'h0, 4'h0, 4'h0);
        check("reset.mode", {30'd0, mode4}, 32'd0);
        check("reset.fc", {24'd0, fc4}, 32'd0);
        check("reset.r8", {24'd0, r8}, 32'd0);

        vsync    = 1'b1;
        mode_req = 2'd0;
        active   = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        x = 10'd256; y = 10'd0;  tick(); rgb4("bars.marker", 4'hF, 4'hF, 4'hF);
        x = 10'd16;  y = 10'd8;  tick(); rgb4("bars.x16y8", 4'hF, 4'h0, 4'hF);
        x = 10'd32;  y = 10'd0;  tick(); rgb4("bars.x32", 4'h0, 4'hF, 4'h0);
        active = 1'b0; x = 10'd256; tick(); rgb4("bars.blank", 4'h0, 4'h0, 4'h0);

        active = 1'b1; mode_req = 2'd1; x = 10'd16; y = 10'd0;
        tick();
        check("latch.hold", {30'd0, mode4}, 32'd0);
        rgb4("latch.bars", 4'h0, 4'h0, 4'hF);
        vsync = 1'b0;
        tick();
        check("latch.mode", {30'd0, mode4}, 32'd1);
        check("latch.fc", {24'd0, fc4}, 32'd1);
        rgb4("latch.oldpix", 4'h0, 4'h0, 4'hF);
        tick();
        rgb4("chk.x16y0", 4'hF, 4'hF, 4'hF);
        y = 10'd16;
        tick();
        rgb4("chk.x16y16", 4'h0, 4'h0, 4'h0);

        for (int i = 0; i < 500; i++) tick();
        check("vs_hold.fc", {24'd0, fc4}, 32'd1);
        check("vs_hold.mode", {30'd0, mode4}, 32'd1);

        frame(2'd2);
        frame(2'd2);
        check("grad.fc", {24'd0, fc4}, 32'd3);
        check("grad.mode", {30'd0, mode4}, 32'd2);
        x = 10'd13; y = 10'd0;
        tick();
        rgb4("grad.f3", 4'h1, 4'h0, 4'hE);

        for (int i = 0; i < 252; i++) frame(2'd2);
        check("wrap.fc255", {24'd0, fc4}, 32'd255);
        y = 10'd32;
        tick();
        rgb4("grad.f255", 4'h0, 4'h2, 4'hF);
        frame(2'd2);
        check("wrap.fc0", {24'd0, fc4}, 32'd0);
        for (int i = 0; i < 768; i++) frame(2'd2);
        check("wrap.fc1024", {24'd0, fc4}, 32'd0);
        check("wrap.fc8", {24'd0, fc8}, 32'd0);
        tick();
        rgb4("grad.f1024", 4'h0, 4'h2, 4'hF);

        frame(2'd3);
        check("solid.mode", {30'd0, mode4}, 32'd3);
        tick();
        rgb4("solid4", 4'hF, 4'h0, 4'h0);
        check("solid8.R", {24'd0, r8}, 32'hFF);
        check("solid8.G", {24'd0, g8}, 32'h00);
        check("solid8.B", {24'd0, b8}, 32'h00);
        active = 1'b0;
        tick();
        check("solid8.blankR", {24'd0, r8}, 32'h00);
        active = 1'b1;
        tick();
        check("solid8.again", {24'd0, r8}, 32'hFF);

        #2;
        rst_n = 1'b0;
        #1;
        rgb4("midrst", 4'h0, 4'h0, 4'h0);
        check("midrst.mode", {30'd0, mode4}, 32'd0);
        check("midrst.fc", {24'd0, fc4}, 32'd1 - 32'd1);
        check("midrst.r8", {24'd0, r8}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        x = 10'd256; y = 10'd0;
        tick();
        rgb4("restart.bars", 4'hF, 4'hF, 4'hF);
        check("restart.fc", {24'd0, fc4}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
